battle_round_controller: RTL and testbench

//  Sequences one player's attack phase of the battleship game over a 5x7 ship map (35 cells).

---
 rtl/battle_round_controller_pkg.sv | 20 ++
 rtl/battle_round_controller_if.sv | 21 ++
 rtl/battle_round_controller_button_sync_edge.sv | 18 +
 rtl/battle_round_controller.sv | 96 +++++++++
 tb/tb_battle_round_controller.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/battle_round_controller_pkg.sv
// battle_round_controller_pkg: states, map geometry and coordinate helpers for the attack phase
package battle_round_controller_pkg;
   localparam int DATA_WIDTH    = 35;
   localparam int COLUNE_SIZE   = 7;
   localparam int TOTAL_COLUNES = 5;
   localparam int MAX_SHOTS     = 20;
   localparam int LED_HOLD      = 8;
   localparam int HOLD_W        = $clog2(LED_HOLD + 1);
   typedef enum logic [2:0] {IDLE = 3'd0, ARMED, CHECK, SHOW, WIN, LOSE} state_t;
   function automatic logic coord_ok(input logic [2:0] x, input logic [2:0] y);
      return int'(x) >= 1 && int'(x) <= TOTAL_COLUNES && int'(y) >= 1 && int'(y) <= COLUNE_SIZE;
   endfunction
   // column x owns slice [(6-x)*7-1 -: 7]; row 1 is the top (MSB) bit of that slice
   function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
      return 6'((TOTAL_COLUNES - int'(x)) * COLUNE_SIZE + (COLUNE_SIZE - int'(y)));
   endfunction
   function automatic logic [5:0] ship_count(input logic [DATA_WIDTH-1:0] m);
      return 6'($countones(m));
   endfunction
endpackage

// File: rtl/battle_round_controller_if.sv
// battle_round_controller_if: game-control bus (master = player/board side, slave = controller)
//   start, selected_map, x/y_coord_code, confirm_n : master -> slave
//   matriz_data, led_rgb, shot_err, ships_left, shots_left, game_state : slave -> master
interface battle_round_controller_if;
   import battle_round_controller_pkg::*;
   logic                  start;
   logic [DATA_WIDTH-1:0] selected_map;
   logic [2:0]            x_coord_code;
   logic [2:0]            y_coord_code;
   logic                  confirm_n;
   logic [DATA_WIDTH-1:0] matriz_data;
   logic [1:0]            led_rgb;
   logic                  shot_err;
   logic [5:0]            ships_left;
   logic [4:0]            shots_left;
   logic [2:0]            game_state;
   modport master (output start, selected_map, x_coord_code, y_coord_code, confirm_n,
                   input  matriz_data, led_rgb, shot_err, ships_left, shots_left, game_state);
   modport slave  (input  start, selected_map, x_coord_code, y_coord_code, confirm_n,
                   output matriz_data, led_rgb, shot_err, ships_left, shots_left, game_state);
endinterface

// File: rtl/battle_round_controller_button_sync_edge.sv
// button_sync_edge: 2-FF synchroniser + falling-edge detect, one-cycle pulse per press
//   clk, reset : clock, sync active-high reset
//   i_btn_n    : raw active-low asynchronous button
//   o_pulse    : one-cycle pulse on each press
module button_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_btn_n,
   output logic o_pulse
);
   logic [2:0] r_sync;
   always_ff @(posedge clk) begin
      if (reset) r_sync <= '1;
      else       r_sync <= {r_sync[1:0], i_btn_n};
   end
   // [1] is the synchronised level, [2] its previous value
   assign o_pulse = r_sync[2] & ~r_sync[1];
endmodule

// File: rtl/battle_round_controller.sv
// battle_round_controller: one player's attack phase over a 5x7 ship map
//   clk, reset : clock, sync active-high reset
//   bus        : battle_round_controller_if.slave (map/coords/button in; matrix, LED, status out)
//   SHOT_LIMIT_EN : when defined, shots are counted and LOSE becomes reachable
module battle_round_controller
   import battle_round_controller_pkg::*;
(
   input logic                       clk,
   input logic                       reset,
   battle_round_controller_if.slave  bus
);
   state_t                r_state, w_next;
   logic [DATA_WIDTH-1:0] r_map, r_shot, r_matriz;
   logic [2:0]            r_x, r_y;
   logic [5:0]            r_ships;
   logic [1:0]            r_led;
   logic [HOLD_W-1:0]     r_hold;
   logic                  w_pulse, w_valid, w_new, w_hit, w_capture, w_fire, w_hold_done, w_no_shots;
   logic [5:0]            w_idx;
   button_sync_edge u_confirm (.clk(clk), .reset(reset), .i_btn_n(bus.confirm_n), .o_pulse(w_pulse));
   assign w_valid     = coord_ok(r_x, r_y);
   assign w_idx       = w_valid ? cell_idx(r_x, r_y) : '0;
   assign w_new       = w_valid && !r_shot[w_idx];
   assign w_hit       = r_map[w_idx];
   assign w_capture   = bus.start && (r_state == IDLE || r_state == WIN || r_state == LOSE);
   assign w_fire      = r_state == CHECK && w_new;
   assign w_hold_done = r_hold == '0;
`ifdef SHOT_LIMIT_EN
   logic [4:0] r_shots;
   always_ff @(posedge clk) begin
      if (reset)                        r_shots <= '0;
      else if (w_capture)               r_shots <= 5'(MAX_SHOTS);
      else if (w_fire && r_shots != '0) r_shots <= r_shots - 5'd1;
   end
   assign w_no_shots     = r_shots == '0;
   assign bus.shots_left = r_shots;
`else
   assign w_no_shots     = 1'b0;
   assign bus.shots_left = '0;
`endif
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE, WIN, LOSE: w_next = bus.start ? ARMED : r_state;
         ARMED:           w_next = w_pulse ? CHECK : ARMED;
         CHECK:           w_next = w_new ? SHOW : ARMED;
         // ships_left was already updated on entry to SHOW, so WIN wins over LOSE
         SHOW:            w_next = !w_hold_done ? SHOW : r_ships == '0 ? WIN : w_no_shots ? LOSE : ARMED;
         default:         w_next = IDLE;
      endcase
   end
   always_comb begin
      bus.shot_err    = r_state == CHECK && !w_new;
      bus.game_state  = r_state;
      bus.led_rgb     = r_led;
      bus.matriz_data = r_matriz;
      bus.ships_left  = r_ships;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_map    <= '0;
         r_shot   <= '0;
         r_matriz <= '1;
         r_x      <= '0;
         r_y      <= '0;
         r_ships  <= '0;
         r_led    <= '0;
         r_hold   <= '0;
      end else begin
         if (w_capture) begin
            r_map    <= bus.selected_map;
            r_shot   <= '0;
            r_matriz <= '1;
            r_ships  <= ship_count(bus.selected_map);
         end
         if (r_state == ARMED && w_pulse) begin
            r_x <= bus.x_coord_code;
            r_y <= bus.y_coord_code;
         end
         if (w_fire) begin
            r_shot[w_idx] <= 1'b1;
            r_hold        <= HOLD_W'(LED_HOLD - 1);
            r_led         <= w_hit ? 2'b10 : 2'b01;
            if (w_hit) r_matriz[w_idx] <= 1'b0;
            if (w_hit && r_ships != '0) r_ships <= r_ships - 6'd1;
         end else if (r_state == SHOW) begin
            if (w_hold_done) r_led <= '0;
            else             r_hold <= r_hold - HOLD_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_battle_round_controller.sv
// tb_battle_round_controller: table-driven shots with a scoreboard queue plus hand sequences
module tb_battle_round_controller;
   import battle_round_controller_pkg::*;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   battle_round_controller_if bus ();
   battle_round_controller dut (.clk(clk), .reset(reset), .bus(bus));
   typedef struct {
      logic [2:0] x;
      logic [2:0] y;
      logic       err;
      logic [1:0] led;
      logic [5:0] ships;
      state_t     st;
   } vec_t;
   vec_t        sb[$];
   vec_t        tbl[10];
   int          errors = 0;
   int          checks = 0;
   int          m_shots = 0;
   logic [34:0] m_mat = '1;
   function automatic int idx(input logic [2:0] x, input logic [2:0] y);
      return (5 - int'(x)) * 7 + (7 - int'(y));
   endfunction
   function automatic vec_t mk(input int x, input int y, input logic err, input logic [1:0] led,
                               input int ships, input state_t st);
      vec_t v;
      v.x = 3'(x); v.y = 3'(y); v.err = err; v.led = led; v.ships = 6'(ships); v.st = st;
      return v;
   endfunction
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask
   task automatic wait_state(input state_t s, input string name);
      int n = 0;
      while (bus.game_state != s && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(bus.game_state), 64'(s));
   endtask
   task automatic start_game(input logic [34:0] m, input int ships);
      bus.selected_map = m;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      m_mat = '1;
`ifdef SHOT_LIMIT_EN
      m_shots = MAX_SHOTS;
`endif
      check("start_state", 64'(bus.game_state), 64'(ARMED));
      check("start_ships", 64'(bus.ships_left), 64'(ships));
      check("start_shots", 64'(bus.shots_left), 64'(m_shots));
      check("start_matriz", 64'(bus.matriz_data), 64'(m_mat));
   endtask
   task automatic shoot(input vec_t v);
      vec_t e;
      int   n = 0;
      sb.push_back(v);
      bus.x_coord_code = v.x;
      bus.y_coord_code = v.y;
      bus.confirm_n = 1'b0;
      while (!bus.shot_err && bus.led_rgb == 2'b00 && n < 30) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      if (n >= 30) begin
         errors++;
         checks++;
         $display("FAIL shot_timeout x=%0d y=%0d: got no response expected err or led", e.x, e.y);
      end else begin
         if (!e.err) begin
`ifdef SHOT_LIMIT_EN
            m_shots--;
`endif
            if (e.led == 2'b10) m_mat[idx(e.x, e.y)] = 1'b0;
         end
         check("shot_err", 64'(bus.shot_err), 64'(e.err));
         check("led", 64'(bus.led_rgb), 64'(e.led));
         check("ships", 64'(bus.ships_left), 64'(e.ships));
         check("shots", 64'(bus.shots_left), 64'(m_shots));
         check("matriz", 64'(bus.matriz_data), 64'(m_mat));
         if (e.err) begin
            @(negedge clk);
            check("err_pulse_width", 64'(bus.shot_err), 64'(0));
            check("state_after_err", 64'(bus.game_state), 64'(e.st));
         end else begin
            n = 0;
            while (bus.led_rgb == e.led && n < 40) begin
               n++;
               @(negedge clk);
            end
            check("led_hold", 64'(n), 64'(LED_HOLD));
            check("state_after_show", 64'(bus.game_state), 64'(e.st));
         end
      end
      bus.confirm_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask
   initial begin
      logic [34:0] ma, mb, mc;
      int nchk;
      bus.start = 1'b0;
      bus.selected_map = '0;
      bus.x_coord_code = '0;
      bus.y_coord_code = '0;
      bus.confirm_n = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_state", 64'(bus.game_state), 64'(IDLE));
      check("rst_matriz", 64'(bus.matriz_data), 64'h7_FFFF_FFFF);
      check("rst_led", 64'(bus.led_rgb), 64'(0));
      check("rst_err", 64'(bus.shot_err), 64'(0));
      check("rst_ships", 64'(bus.ships_left), 64'(0));
      check("rst_shots", 64'(bus.shots_left), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      check("idle_hold", 64'(bus.game_state), 64'(IDLE));
      ma = '0;
      ma[34] = 1'b1;
      ma[25] = 1'b1;
      ma[0] = 1'b1;
      tbl[0] = mk(3, 4, 1'b0, 2'b01, 3, ARMED);
      tbl[1] = mk(0, 2, 1'b1, 2'b00, 3, ARMED);
      tbl[2] = mk(6, 2, 1'b1, 2'b00, 3, ARMED);
      tbl[3] = mk(2, 0, 1'b1, 2'b00, 3, ARMED);
      tbl[4] = mk(3, 4, 1'b1, 2'b00, 3, ARMED);
      tbl[5] = mk(7, 7, 1'b1, 2'b00, 3, ARMED);
      tbl[6] = mk(1, 1, 1'b0, 2'b10, 2, ARMED);
      tbl[7] = mk(2, 3, 1'b0, 2'b10, 1, ARMED);
      tbl[8] = mk(2, 3, 1'b1, 2'b00, 1, ARMED);
      tbl[9] = mk(5, 7, 1'b0, 2'b10, 0, WIN);
      start_game(ma, 3);
      for (int i = 0; i < 10; i++) shoot(tbl[i]);
      bus.x_coord_code = 3'd4;
      bus.y_coord_code = 3'd4;
      bus.confirm_n = 1'b0;
      repeat (8) @(negedge clk);
      bus.confirm_n = 1'b1;
      repeat (4) @(negedge clk);
      check("win_frozen_state", 64'(bus.game_state), 64'(WIN));
      check("win_frozen_matriz", 64'(bus.matriz_data), 64'(m_mat));
      mb = '0;
      mb[34] = 1'b1;
      start_game(mb, 1);
      shoot(mk(1, 1, 1'b0, 2'b10, 0, WIN));
      check("bit34_hit", 64'(bus.matriz_data[34]), 64'(0));
      start_game('0, 0);
      shoot(mk(4, 4, 1'b0, 2'b01, 0, WIN));
      mc = '0;
      mc[34] = 1'b1;
      mc[33] = 1'b1;
      start_game(mc, 2);
      bus.x_coord_code = 3'd2;
      bus.y_coord_code = 3'd2;
      bus.confirm_n = 1'b0;
      nchk = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.game_state == CHECK) nchk++;
      end
      bus.confirm_n = 1'b1;
      repeat (4) @(negedge clk);
`ifdef SHOT_LIMIT_EN
      m_shots--;
`endif
      check("hold_one_shot", 64'(nchk), 64'(1));
      check("hold_state", 64'(bus.game_state), 64'(ARMED));
      check("hold_shots", 64'(bus.shots_left), 64'(m_shots));
      bus.x_coord_code = 3'd3;
      bus.y_coord_code = 3'd3;
      bus.confirm_n = 1'b0;
      nchk = 0;
      for (int n = 0; n < 20 && bus.game_state != SHOW; n++) begin
         @(negedge clk);
         if (bus.game_state == CHECK) nchk++;
      end
      bus.confirm_n = 1'b1;
      repeat (2) @(negedge clk);
      bus.x_coord_code = 3'd4;
      bus.y_coord_code = 3'd4;
      bus.confirm_n = 1'b0;
      repeat (3) @(negedge clk);
      bus.confirm_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.game_state == CHECK) nchk++;
      end
`ifdef SHOT_LIMIT_EN
      m_shots--;
`endif
      check("show_press_ignored", 64'(nchk), 64'(1));
      check("show_press_state", 64'(bus.game_state), 64'(ARMED));
      check("show_press_shots", 64'(bus.shots_left), 64'(m_shots));
      check("show_press_ships", 64'(bus.ships_left), 64'(2));
      bus.x_coord_code = 3'd1;
      bus.y_coord_code = 3'd1;
      bus.confirm_n = 1'b0;
      wait_state(SHOW, "reach_show");
      check("show_led", 64'(bus.led_rgb), 64'(2'b10));
      reset = 1'b1;
      bus.confirm_n = 1'b1;
      @(negedge clk);
      check("midrst_state", 64'(bus.game_state), 64'(IDLE));
      check("midrst_led", 64'(bus.led_rgb), 64'(0));
      check("midrst_matriz", 64'(bus.matriz_data), 64'h7_FFFF_FFFF);
      check("midrst_ships", 64'(bus.ships_left), 64'(0));
      check("midrst_shots", 64'(bus.shots_left), 64'(0));
      reset = 1'b0;
      repeat (2) @(negedge clk);
`ifdef SHOT_LIMIT_EN
      for (int g = 0; g < 2; g++) begin
         int k = 0;
         start_game(mb, 1);
         for (int x = 1; x <= 5; x++)
            for (int y = 1; y <= 7; y++)
               if (!(x == 1 && y == 1) && k < 19 + (g == 0 ? 1 : 0)) begin
                  shoot(mk(x, y, 1'b0, 2'b01, 1, (g == 0 && k == 19) ? LOSE : ARMED));
                  k++;
               end
         if (g == 0) check("lose_shots", 64'(bus.shots_left), 64'(0));
         else shoot(mk(1, 1, 1'b0, 2'b10, 0, WIN));
      end
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
